muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller that owns the HI/LO register pair for the processor's RTYPE1 `MUL`/`DIV`/`MFHI` path. It accepts one operation at a time from the execute stage and runs a 32-step iterative shift-add multiply or restoring divide. It applies sign correction, writes HI/LO, and holds `busy` so the pipeline stalls any dependent `MFHI`/`MFLO` or new mul/div. It sits beside the ALU. The ALU keeps the single-cycle ops, and this block replaces the combinational divide/multiply.

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/muldiv_ctrl_if.sv | 32 +++
 rtl/muldiv_ctrl_datapath.sv | 59 +++++
 rtl/muldiv_ctrl.sv | 150 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encodings and small decode helpers for the
// iterative multiply/divide unit that owns HI/LO.
package muldiv_ctrl_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> mul/div unit bundle: issue request, MTHI/MTLO writes,
// status pulses and the registered HI/LO pair.
interface muldiv_ctrl_if
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) ();

  logic             start;
  md_op_e           op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/muldiv_ctrl_datapath.sv
// Unsigned shift-add multiplier / restoring divider, one step per cycle.
// load seeds the 2*WIDTH accumulator; result is valid after WIDTH steps.
module muldiv_datapath #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] result_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic               sub_ok;

  // Multiply: acc = {partial product, remaining multiplier bits}, shift right.
  assign addend  = acc_q[0] ? opnd_q : '0;
  assign add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  // Divide: acc = {partial remainder, dividend/quotient bits}, shift left.
  assign sub_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
  assign sub_ok   = ~sub_diff[WIDTH];

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (load_i) begin
      opnd_d = is_div_i ? b_i : a_i;
      acc_d  = {{WIDTH{1'b0}}, (is_div_i ? a_i : b_i)};
    end else if (step_i) begin
      if (is_div_i) begin
        acc_d = {(sub_ok ? sub_diff[WIDTH-1:0] : acc_q[2*WIDTH-2:WIDTH-1]),
                 acc_q[WIDTH-2:0], sub_ok};
      end else begin
        acc_d = {add_sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

  assign result_o = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for MULT/MULTU/DIV/DIVU: STEPS+2 cycles from accept to done.
// No queue: start is ignored while busy, caller must stall on busy.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int STEPS = WIDTH
) (
  input logic        clk,
  input logic        rst,
  muldiv_ctrl_if.slave md
);

  localparam int CW = $clog2(STEPS + 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               dz_q, dz_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  logic               dp_load, dp_step, dp_is_div;
  logic               op_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] dp_res, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_signed = md_is_signed(md.op);
  assign a_abs = (op_signed && md.rs_val[WIDTH-1]) ? -md.rs_val : md.rs_val;
  assign b_abs = (op_signed && md.rt_val[WIDTH-1]) ? -md.rt_val : md.rt_val;

  // The datapath needs the mode before it is latched, on the load cycle.
  assign dp_is_div = (state_q == IDLE) ? md_is_div(md.op) : is_div_q;

  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load_i   (dp_load),
    .step_i   (dp_step),
    .is_div_i (dp_is_div),
    .a_i      (a_abs),
    .b_i      (b_abs),
    .result_o (dp_res)
  );

  assign prod_fix = neg_lo_q ? -dp_res : dp_res;
  assign quo_fix  = neg_lo_q ? -dp_res[WIDTH-1:0] : dp_res[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -dp_res[2*WIDTH-1:WIDTH] : dp_res[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    rs_d     = rs_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    dp_load  = 1'b0;
    dp_step  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (md.hi_we) hi_d = md.wdata;
        if (md.lo_we) lo_d = md.wdata;
        if (md.start) begin
          state_d  = RUN;
          cnt_d    = '0;
          dp_load  = 1'b1;
          is_div_d = md_is_div(md.op);
          dz_d     = md_is_div(md.op) && (md.rt_val == '0);
          neg_lo_d = op_signed && (md.rs_val[WIDTH-1] ^ md.rt_val[WIDTH-1]);
          neg_hi_d = op_signed && md.rs_val[WIDTH-1];
          rs_d     = md.rs_val;
        end
      end
      RUN: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        div0_d  = dz_q;
        // Divide by zero bypasses the iteration result entirely.
        if (dz_q) begin
          hi_d = rs_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      rs_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      rs_q     <= rs_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.div0 = div0_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: hand-computed vectors, busy/done timing,
// MTHI/MTLO interplay, abort by reset, and a signed/unsigned multiply sweep.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk;
  logic rst;

  muldiv_ctrl_if #(.WIDTH(32)) md ();

  muldiv_ctrl #(.WIDTH(32), .STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a request for one cycle starting at the current negedge.
  task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    md.op     = o;
    md.rs_val = a;
    md.rt_val = b;
    md.start  = 1'b1;
    @(negedge clk);
    md.start  = 1'b0;
    md.hi_we  = 1'b0;
    md.lo_we  = 1'b0;
  endtask

  task automatic wait_done(output logic [31:0] h, output logic [31:0] l,
                           output logic dz, output int bcnt);
    int n = 0;
    bcnt = 0;
    while (!md.done && n < 100) begin
      if (md.busy) bcnt++;
      n++;
      @(negedge clk);
    end
    check_eq("done_seen", 32'(md.done), 32'd1);
    h  = md.hi;
    l  = md.lo;
    dz = md.div0;
  endtask

  task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output int bcnt);
    @(negedge clk);
    issue(o, a, b);
    wait_done(h, l, dz, bcnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]        h, l, a, b;
    logic               dz;
    int                 bc, n_done;
    logic               sgn;
    logic signed [63:0] sa, sb;
    logic [63:0]        e;

    rst       = 1'b1;
    md.start  = 1'b0;
    md.op     = MD_MULT;
    md.rs_val = '0;
    md.rt_val = '0;
    md.hi_we  = 1'b0;
    md.lo_we  = 1'b0;
    md.wdata  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", 32'(md.busy), 32'd0);
    check_eq("rst_done", 32'(md.done), 32'd0);
    check_eq("rst_div0", 32'(md.div0), 32'd0);
    check_eq("rst_hi", md.hi, 32'h0);
    check_eq("rst_lo", md.lo, 32'h0);

    // MULT -3 * 7 = -21
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, h, l, dz, bc);
    check_eq("mult_hi", h, 32'hFFFF_FFFF);
    check_eq("mult_lo", l, 32'hFFFF_FFEB);
    check_eq("mult_busy_cycles", 32'(bc), 32'd33);
    check_eq("mult_busy_at_done", 32'(md.busy), 32'd0);
    check_eq("mult_div0", 32'(dz), 32'd0);
    @(negedge clk);
    check_eq("done_one_cycle", 32'(md.done), 32'd0);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l, dz, bc);
    check_eq("multu_hi", h, 32'hFFFF_FFFE);
    check_eq("multu_lo", l, 32'h0000_0001);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, h, l, dz, bc);
    check_eq("div_neg_lo", l, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", h, 32'hFFFF_FFFF);

    run_op(MD_DIVU, 32'd7, 32'd2, h, l, dz, bc);
    check_eq("divu_lo", l, 32'd3);
    check_eq("divu_hi", h, 32'd1);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, h, l, dz, bc);
    check_eq("div_ovf_lo", l, 32'h8000_0000);
    check_eq("div_ovf_hi", h, 32'h0);
    check_eq("div_ovf_div0", 32'(dz), 32'd0);

    run_op(MD_DIV, 32'd5, 32'd0, h, l, dz, bc);
    check_eq("div0_lo", l, 32'hFFFF_FFFF);
    check_eq("div0_hi", h, 32'd5);
    check_eq("div0_flag", 32'(dz), 32'd1);

    run_op(MD_MULT, 32'd2, 32'd3, h, l, dz, bc);
    check_eq("after_div0_lo", l, 32'd6);
    check_eq("after_div0_flag", 32'(dz), 32'd0);

    // Second start five cycles in must be ignored.
    @(negedge clk);
    issue(MD_MULT, 32'd6, 32'd7);
    repeat (4) @(negedge clk);
    md.op     = MD_DIVU;
    md.rs_val = 32'd100;
    md.rt_val = 32'd7;
    md.start  = 1'b1;
    @(negedge clk);
    md.start  = 1'b0;
    wait_done(h, l, dz, bc);
    check_eq("ignored_start_lo", l, 32'd42);
    check_eq("ignored_start_hi", h, 32'd0);

    // Start in the done cycle is accepted: back-to-back every 34 cycles.
    issue(MD_DIVU, 32'd100, 32'd7);
    check_eq("b2b_accept", 32'(md.busy), 32'd1);
    wait_done(h, l, dz, bc);
    check_eq("b2b_lo", l, 32'd14);
    check_eq("b2b_hi", h, 32'd2);
    check_eq("b2b_busy_cycles", 32'(bc), 32'd33);

    // MTHI while busy is dropped.
    @(negedge clk);
    issue(MD_MULTU, 32'd3, 32'd5);
    repeat (2) @(negedge clk);
    md.hi_we = 1'b1;
    md.wdata = 32'h0000_1234;
    @(negedge clk);
    md.hi_we = 1'b0;
    check_eq("hi_we_busy", md.hi, 32'd2);
    wait_done(h, l, dz, bc);
    check_eq("mulu_small_lo", l, 32'd15);
    check_eq("mulu_small_hi", h, 32'd0);

    // MTHI / MTLO in idle land on the next edge.
    @(negedge clk);
    md.hi_we = 1'b1;
    md.wdata = 32'h0000_1234;
    @(negedge clk);
    md.hi_we = 1'b0;
    check_eq("hi_we_idle_hi", md.hi, 32'h0000_1234);
    check_eq("hi_we_idle_lo", md.lo, 32'd15);
    md.lo_we = 1'b1;
    md.wdata = 32'h0000_ABCD;
    @(negedge clk);
    md.lo_we = 1'b0;
    check_eq("lo_we_idle_lo", md.lo, 32'h0000_ABCD);
    check_eq("lo_we_idle_hi", md.hi, 32'h0000_1234);

    // MTHI together with an accepted start applies, then FIX overwrites.
    md.hi_we = 1'b1;
    md.wdata = 32'h0000_5555;
    issue(MD_MULT, 32'd4, 32'd4);
    check_eq("hi_we_at_start", md.hi, 32'h0000_5555);
    check_eq("busy_after_start", 32'(md.busy), 32'd1);
    wait_done(h, l, dz, bc);
    check_eq("overwrite_hi", h, 32'd0);
    check_eq("overwrite_lo", l, 32'd16);

    for (int i = 0; i < 100; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = (i % 2) == 0;
      if (i % 10 == 3) a = 32'h8000_0000;
      if (sgn) begin
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        e  = sa * sb;
        run_op(MD_MULT, a, b, h, l, dz, bc);
      end else begin
        e  = {32'h0, a} * {32'h0, b};
        run_op(MD_MULTU, a, b, h, l, dz, bc);
      end
      check_eq("sweep_hi", h, e[63:32]);
      check_eq("sweep_lo", l, e[31:0]);
    end

    // Reset in RUN cycle 10 discards the operation.
    @(negedge clk);
    issue(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(md.busy), 32'd0);
    check_eq("abort_done", 32'(md.done), 32'd0);
    check_eq("abort_hi", md.hi, 32'h0);
    check_eq("abort_lo", md.lo, 32'h0);
    n_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (md.done) n_done++;
    end
    check_eq("abort_no_done", 32'(n_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
